// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB for the isa_op
// instruction set and drives the datapath selects, with a bounded memory handshake.
module multicycle_control #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] opcode,
   input  logic       alu_zero,
   input  logic       mem_ready,
   output logic       imem_req,
   output logic       ir_we,
   output logic       pc_we,
   output logic       pc_src,
   output logic [2:0] alu_func,
   output logic       alu_src_imm,
   output logic       alu_a_zero,
   output logic       alu_swap,
   output logic       dmem_req,
   output logic       dmem_we,
   output logic       reg_we,
   output logic [1:0] data_sel,
   output logic       bus_err,
   output logic       illegal,
   output logic [2:0] state_o
);

   typedef enum logic [3:0] {
      ISA_ADD  = 4'd0, ISA_SUB  = 4'd1, ISA_AND  = 4'd2, ISA_OR   = 4'd3,
      ISA_SLT  = 4'd4, ISA_JAL  = 4'd5, ISA_BEQ  = 4'd6, ISA_LOAD = 4'd7,
      ISA_STOR = 4'd8, ISA_ADDI = 4'd9, ISA_LUI  = 4'd10
   } isa_op_t;

   typedef enum logic [2:0] {
      ALU_NOP = 3'd0, ALU_ADD = 3'd1, ALU_SUB = 3'd2, ALU_AND = 3'd3,
      ALU_OR  = 3'd4, ALU_GT  = 3'd5, ALU_ET  = 3'd6
   } alu_func_t;

   typedef enum logic [1:0] {
      DATA_NOP = 2'd0, DATA_ALU = 2'd1, DATA_WORD = 2'd2, DATA_PC = 2'd3
   } data_s_t;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
      S_MEM  = 3'd4, S_WB    = 3'd5, S_TRAP   = 3'd6
   } state_t;

   localparam int CW = $clog2(MEM_TIMEOUT);

   state_t        state_q, state_d;
   isa_op_t       op_q, op_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          illegal_q, illegal_d;

   alu_func_t     ex_func_s;
   logic          ex_imm_s, ex_azero_s, ex_swap_s;
   logic          hold_s, timeout_s;

   assign timeout_s = (cnt_q == CW'(MEM_TIMEOUT - 1)) && !mem_ready;
   // ALU/ADDI/LUI keep their EXEC operand selects stable through WB
   assign hold_s    = op_q inside {ISA_ADD, ISA_SUB, ISA_AND, ISA_OR, ISA_SLT, ISA_ADDI, ISA_LUI};
   assign illegal   = illegal_q;
   assign state_o   = state_q;

   // State, latched opcode, handshake counter and sticky illegal flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         op_q      <= ISA_ADD;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
      end
   end

   // ALU control word for the latched opcode, shared by EXEC, MEM and WB
   always_comb begin
      ex_func_s  = ALU_NOP;
      ex_imm_s   = 1'b0;
      ex_azero_s = 1'b0;
      ex_swap_s  = 1'b0;
      case (op_q)
         ISA_ADD: ex_func_s = ALU_ADD;
         ISA_SUB: ex_func_s = ALU_SUB;
         ISA_AND: ex_func_s = ALU_AND;
         ISA_OR:  ex_func_s = ALU_OR;
         ISA_SLT: begin
            ex_func_s = ALU_GT;
            ex_swap_s = 1'b1;
         end
         ISA_BEQ: ex_func_s = ALU_ET;
         ISA_LOAD, ISA_STOR, ISA_ADDI: begin
            ex_func_s = ALU_ADD;
            ex_imm_s  = 1'b1;
         end
         ISA_LUI: begin
            ex_func_s  = ALU_ADD;
            ex_imm_s   = 1'b1;
            ex_azero_s = 1'b1;
         end
         default: ex_func_s = ALU_NOP;
      endcase
   end

   // Next-state and Moore outputs; the counter only survives a stalled request cycle
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      cnt_d       = '0;
      illegal_d   = illegal_q;
      imem_req    = 1'b0;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      pc_src      = 1'b0;
      alu_func    = ALU_NOP;
      alu_src_imm = 1'b0;
      alu_a_zero  = 1'b0;
      alu_swap    = 1'b0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      reg_we      = 1'b0;
      data_sel    = DATA_NOP;
      bus_err     = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            imem_req = 1'b1;
            if (mem_ready) begin
               ir_we   = 1'b1;
               state_d = S_DECODE;
            end else if (timeout_s) begin
               bus_err = 1'b1;
               state_d = S_FETCH;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DECODE: begin
            op_d = isa_op_t'(opcode);
            if (opcode > 4'd10) begin
               illegal_d = 1'b1;
               state_d   = S_TRAP;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            alu_func    = ex_func_s;
            alu_src_imm = ex_imm_s;
            alu_a_zero  = ex_azero_s;
            alu_swap    = ex_swap_s;
            case (op_q)
               ISA_BEQ: begin
                  pc_we   = 1'b1;
                  pc_src  = alu_zero;
                  state_d = S_FETCH;
               end
               ISA_LOAD, ISA_STOR: state_d = S_MEM;
               default:            state_d = S_WB;
            endcase
         end
         S_MEM: begin
            dmem_req    = 1'b1;
            dmem_we     = (op_q == ISA_STOR);
            alu_func    = ex_func_s;
            alu_src_imm = ex_imm_s;
            if (mem_ready) begin
               if (op_q == ISA_STOR) begin
                  pc_we   = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end else if (timeout_s) begin
               bus_err = 1'b1;
               state_d = S_FETCH;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_WB: begin
            reg_we  = 1'b1;
            pc_we   = 1'b1;
            pc_src  = (op_q == ISA_JAL);
            state_d = S_FETCH;
            case (op_q)
               ISA_LOAD: data_sel = DATA_WORD;
               ISA_JAL:  data_sel = DATA_PC;
               default:  data_sel = DATA_ALU;
            endcase
            if (hold_s) begin
               alu_func    = ex_func_s;
               alu_src_imm = ex_imm_s;
               alu_a_zero  = ex_azero_s;
               alu_swap    = ex_swap_s;
            end else begin
               alu_func = ALU_NOP;
            end
         end
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: one task per scenario, each with its own
// hand-computed expected states and strobes.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       rst_n, alu_zero, mem_ready;
   logic [3:0] opcode;
   logic       imem_req, ir_we, pc_we, pc_src, alu_src_imm, alu_a_zero, alu_swap;
   logic       dmem_req, dmem_we, reg_we, bus_err, illegal;
   logic [2:0] alu_func, state_o;
   logic [1:0] data_sel;
   logic [10:0] strb_s;
   logic [5:0]  ctl_s;
   int vec_cnt = 0;
   int err_cnt = 0;

   multicycle_control #(.MEM_TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_zero(alu_zero), .mem_ready(mem_ready),
      .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_func(alu_func),
      .alu_src_imm(alu_src_imm), .alu_a_zero(alu_a_zero), .alu_swap(alu_swap),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_we(reg_we), .data_sel(data_sel),
      .bus_err(bus_err), .illegal(illegal), .state_o(state_o)
   );

   always #5 clk = ~clk;

   assign strb_s = {imem_req, ir_we, pc_we, pc_src, alu_src_imm, alu_a_zero, alu_swap,
                    dmem_req, dmem_we, reg_we, bus_err};
   assign ctl_s  = {alu_func, alu_src_imm, alu_a_zero, alu_swap};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; opcode = 4'd0; mem_ready = 1'b1; alu_zero = 1'b0;
      step(); step(); #1;
      vec_cnt++;
      if ({state_o, strb_s, alu_func, data_sel, illegal} !== 20'd0) begin
         err_cnt++;
         $display("FAIL reset: state=%0d strb=%b func=%0d sel=%0d ill=%b, required all 0",
                  state_o, strb_s, alu_func, data_sel, illegal);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_add();
      logic [2:0] exp_st [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5};
      opcode = 4'd0; mem_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         vec_cnt++;
         if (state_o !== exp_st[i]) begin
            err_cnt++; $display("FAIL add_state[%0d]: got %0d required %0d", i, state_o, exp_st[i]);
         end
         if (i == 1) begin
            vec_cnt++;
            if ({imem_req, ir_we} !== 2'b11) begin
               err_cnt++; $display("FAIL add_fetch: imem_req,ir_we=%b required 11", {imem_req, ir_we});
            end
         end
         if (i == 3) begin
            vec_cnt++;
            if (alu_func !== 3'd1) begin
               err_cnt++; $display("FAIL add_exec_func: got %0d required 1", alu_func);
            end
         end
         if (i == 4) begin
            vec_cnt++;
            if ({reg_we, pc_we, pc_src, data_sel} !== 5'b110_01) begin
               err_cnt++; $display("FAIL add_wb: reg_we,pc_we,pc_src,sel=%b required 11001",
                                   {reg_we, pc_we, pc_src, data_sel});
            end
         end
         step();
      end
      #1;
      vec_cnt++;
      if (state_o !== 3'd1) begin
         err_cnt++; $display("FAIL add_latency: state=%0d required 1", state_o);
      end
   endtask

   task automatic test_load_wait();
      logic       mr     [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [2:0] exp_st [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd5};
      opcode = 4'd7;
      for (int i = 0; i < 7; i++) begin
         mem_ready = mr[i];
         if (i >= 2) opcode = 4'hF;
         #1;
         vec_cnt++;
         if ({state_o, dmem_we} !== {exp_st[i], 1'b0}) begin
            err_cnt++; $display("FAIL load_state[%0d]: state=%0d dmem_we=%b required %0d/0",
                                i, state_o, dmem_we, exp_st[i]);
         end
         if (exp_st[i] == 3'd4) begin
            vec_cnt++;
            if (dmem_req !== 1'b1) begin
               err_cnt++; $display("FAIL load_mem_req[%0d]: got %b required 1", i, dmem_req);
            end
         end
         if (exp_st[i] == 3'd5) begin
            vec_cnt++;
            if ({data_sel, reg_we} !== 3'b10_1) begin
               err_cnt++; $display("FAIL load_wb: sel=%0d reg_we=%b required 2/1", data_sel, reg_we);
            end
         end
         step();
      end
      #1;
      vec_cnt++;
      if (state_o !== 3'd1) begin
         err_cnt++; $display("FAIL load_latency: state=%0d required 1", state_o);
      end
   endtask

   task automatic test_beq();
      logic [2:0] exp_st [3] = '{3'd1, 3'd2, 3'd3};
      for (int z = 0; z < 2; z++) begin
         logic zv;
         zv = (z == 0);
         opcode = 4'd6;
         for (int i = 0; i < 3; i++) begin
            mem_ready = (i == 0); alu_zero = zv;
            #1;
            vec_cnt++;
            if (state_o !== exp_st[i]) begin
               err_cnt++; $display("FAIL beq_state[%0d]: got %0d required %0d", i, state_o, exp_st[i]);
            end
            if (i == 2) begin
               vec_cnt++;
               if ({pc_we, pc_src, reg_we, alu_func} !== {1'b1, zv, 1'b0, 3'd6}) begin
                  err_cnt++; $display("FAIL beq_exec z=%b: pc_we,pc_src,reg_we,func=%b required %b",
                                      zv, {pc_we, pc_src, reg_we, alu_func}, {1'b1, zv, 1'b0, 3'd6});
               end
            end
            step();
         end
      end
      #1;
      vec_cnt++;
      if (state_o !== 3'd1) begin
         err_cnt++; $display("FAIL beq_latency: state=%0d required 1", state_o);
      end
   endtask

   task automatic test_alu_ops();
      logic [3:0] ops  [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9, 4'd10, 4'd8};
      logic [5:0] ctl  [8] = '{6'b010_000, 6'b011_000, 6'b100_000, 6'b101_001,
                               6'b000_000, 6'b001_100, 6'b001_110, 6'b001_100};
      logic [1:0] dsel [8] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd1, 2'd1, 2'd0};
      logic       pcs  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int k = 0; k < 8; k++) begin
         opcode = ops[k];
         for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 0) || (i == 3);
            #1;
            if (i == 2) begin
               vec_cnt++;
               if ({state_o, ctl_s} !== {3'd3, ctl[k]}) begin
                  err_cnt++; $display("FAIL op%0d_exec: state=%0d ctl=%b required 3/%b",
                                      ops[k], state_o, ctl_s, ctl[k]);
               end
            end
            if (i == 3 && ops[k] == 4'd8) begin
               vec_cnt++;
               if ({state_o, dmem_req, dmem_we, pc_we, pc_src, reg_we, ctl_s} !== {3'd4, 5'b11100, ctl[k]}) begin
                  err_cnt++; $display("FAIL stor_mem: state=%0d req,we,pc_we,pc_src,reg_we=%b ctl=%b",
                                      state_o, {dmem_req, dmem_we, pc_we, pc_src, reg_we}, ctl_s);
               end
            end
            if (i == 3 && ops[k] != 4'd8) begin
               vec_cnt++;
               if ({state_o, reg_we, pc_we, pc_src, data_sel, ctl_s} !==
                   {3'd5, 2'b11, pcs[k], dsel[k], ctl[k]}) begin
                  err_cnt++; $display("FAIL op%0d_wb: state=%0d reg,pc_we,pc_src=%b sel=%0d ctl=%b required sel=%0d ctl=%b",
                                      ops[k], state_o, {reg_we, pc_we, pc_src}, data_sel, ctl_s, dsel[k], ctl[k]);
               end
            end
            step();
         end
      end
      #1;
      vec_cnt++;
      if (state_o !== 3'd1) begin
         err_cnt++; $display("FAIL alu_ops_end: state=%0d required 1", state_o);
      end
   endtask

   task automatic test_timeout();
      int pulses = 0;
      mem_ready = 1'b0; opcode = 4'd0;
      for (int i = 0; i < 18; i++) begin
         #1;
         vec_cnt++;
         if ({state_o, ir_we, pc_we, reg_we, bus_err} !== {3'd1, 3'b000, (i == 15)}) begin
            err_cnt++; $display("FAIL timeout[%0d]: state=%0d ir_we,pc_we,reg_we=%b bus_err=%b required bus_err=%b",
                                i, state_o, {ir_we, pc_we, reg_we}, bus_err, (i == 15));
         end
         if (bus_err === 1'b1) pulses++;
         step();
      end
      vec_cnt++;
      if (pulses != 1) begin
         err_cnt++; $display("FAIL timeout_pulses: got %0d required 1", pulses);
      end
   endtask

   task automatic test_stor_reset();
      logic [2:0] exp_st [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
      opcode = 4'd8;
      for (int i = 0; i < 4; i++) begin
         mem_ready = (i == 0);
         #1;
         vec_cnt++;
         if (state_o !== exp_st[i]) begin
            err_cnt++; $display("FAIL stor_state[%0d]: got %0d required %0d", i, state_o, exp_st[i]);
         end
         if (i < 3) step();
      end
      vec_cnt++;
      if ({dmem_req, dmem_we} !== 2'b11) begin
         err_cnt++; $display("FAIL stor_req: req,we=%b required 11", {dmem_req, dmem_we});
      end
      rst_n = 1'b0;
      #1;
      vec_cnt++;
      if ({state_o, dmem_req, pc_we} !== 5'd0) begin
         err_cnt++; $display("FAIL stor_async_rst: state=%0d req=%b pc_we=%b required 0", state_o, dmem_req, pc_we);
      end
      step();
      rst_n = 1'b1; mem_ready = 1'b1;
      #1;
      vec_cnt++;
      if (state_o !== 3'd0) begin
         err_cnt++; $display("FAIL stor_release: state=%0d required 0", state_o);
      end
      step(); #1;
      vec_cnt++;
      if (state_o !== 3'd1) begin
         err_cnt++; $display("FAIL stor_refetch: state=%0d required 1", state_o);
      end
   endtask

   task automatic test_illegal();
      opcode = 4'hC; mem_ready = 1'b1;
      step(); #1;
      vec_cnt++;
      if ({state_o, illegal} !== {3'd2, 1'b0}) begin
         err_cnt++; $display("FAIL ill_decode: state=%0d ill=%b required 2/0", state_o, illegal);
      end
      step();
      for (int n = 0; n < 50; n++) begin
         #1;
         vec_cnt++;
         if ({state_o, illegal, strb_s, alu_func, data_sel} !== {3'd6, 1'b1, 16'd0}) begin
            err_cnt++; $display("FAIL ill_trap[%0d]: state=%0d ill=%b strb=%b func=%0d sel=%0d required 6/1/0",
                                n, state_o, illegal, strb_s, alu_func, data_sel);
         end
         opcode = 4'($urandom_range(0, 15)); mem_ready = n[0]; alu_zero = n[1];
         step();
      end
      rst_n = 1'b0;
      #1;
      vec_cnt++;
      if ({state_o, illegal} !== 4'd0) begin
         err_cnt++; $display("FAIL ill_reset: state=%0d ill=%b required 0/0", state_o, illegal);
      end
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_add();
      test_load_wait();
      test_beq();
      test_alu_ops();
      test_timeout();
      test_stor_reset();
      test_illegal();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
